// File: rtl/sharp_pkg.sv
// Shared constants and FSM state type for the Sharp memory-LCD line feeder.
package sharp_pkg;
  localparam int LINE_BITS     = 144;
  localparam int WORD_W        = 16;
  localparam int LINES_DEFAULT = 168;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_PRESENT,
    ST_DONE
  } feed_state_e;
endpackage

// File: rtl/sharp_word_packer.sv
// Shifts 16-bit frame-buffer words into the 144-bit line register, word 0 ending at the MSBs.
// SHARP_FEEDER_INVERT_EN: invert each word before storage (frame buffer 1=black, panel 1=white).
module sharp_word_packer
  import sharp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WORD_W-1:0]    word,
  output logic [LINE_BITS-1:0] line
);

  logic [WORD_W-1:0] word_st;

`ifdef SHARP_FEEDER_INVERT_EN
  assign word_st = ~word;
`else
  assign word_st = word;
`endif

  // Words arrive in ascending order, so shifting left lands word w at [143-16*w -: 16].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line <= '0;
    else if (load) line <= {line[LINE_BITS-WORD_W-1:0], word_st};
  end

endmodule

// File: rtl/sharp_line_feeder.sv
// Streams one frame from a 16-bit frame buffer into 144-bit gate lines for a Sharp memory LCD.
// Optional macro SHARP_FEEDER_INVERT_EN (handled in sharp_word_packer) inverts stored pixels.
module sharp_line_feeder
  import sharp_pkg::*;
#(
  parameter int LINES          = LINES_DEFAULT,
  parameter int WORDS_PER_LINE = 9
) (
  input  logic                 clk_12mhz,
  input  logic                 rst_n,
  input  logic                 frame_start,
  output logic                 mem_rd_en,
  output logic [10:0]          mem_addr,
  input  logic [WORD_W-1:0]    mem_rd_data,
  output logic                 line_valid,
  input  logic                 line_ready,
  output logic [7:0]           line_addr,
  output logic [LINE_BITS-1:0] line_data,
  output logic                 frame_busy,
  output logic                 frame_done
);

  localparam int WCW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  feed_state_e    state, nxt;
  logic [WCW-1:0] word_cnt;
  logic [7:0]     line_cnt;
  logic [10:0]    base;
  logic           last_word, last_line;

  assign last_word = (word_cnt == WCW'(WORDS_PER_LINE - 1));
  assign last_line = (line_cnt == 8'(LINES));
  assign line_addr = line_cnt;

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (frame_start) nxt = ST_FETCH;
      ST_FETCH:   nxt = ST_WAIT_RD;
      ST_WAIT_RD: nxt = last_word ? ST_PRESENT : ST_FETCH;
      ST_PRESENT: if (line_ready) nxt = last_line ? ST_DONE : ST_FETCH;
      ST_DONE:    nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en  = (state == ST_FETCH);
    mem_addr   = (state == ST_FETCH) ? base + 11'(word_cnt) : '0;
    line_valid = (state == ST_PRESENT);
    frame_busy = (state != ST_IDLE);
    frame_done = (state == ST_DONE);
  end

  // base tracks (line-1)*WORDS_PER_LINE incrementally so no multiplier is needed.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      line_cnt <= '0;
      base     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (frame_start) begin
          line_cnt <= 8'd1;
          word_cnt <= '0;
          base     <= '0;
        end
        ST_WAIT_RD: if (!last_word) word_cnt <= word_cnt + 1'b1;
        ST_PRESENT: if (line_ready && !last_line) begin
          line_cnt <= line_cnt + 8'd1;
          word_cnt <= '0;
          base     <= base + 11'(WORDS_PER_LINE);
        end
        default: ;
      endcase
    end
  end

  sharp_word_packer u_packer (
    .clk   (clk_12mhz),
    .rst_n (rst_n),
    .load  (state == ST_WAIT_RD),
    .word  (mem_rd_data),
    .line  (line_data)
  );

endmodule

// File: tb/tb_sharp_line_feeder.sv
// Scoreboard bench for sharp_line_feeder: frame-level reference model, randomized memory and backpressure.
module tb_sharp_line_feeder;
  localparam int LINES = 168;
  localparam int WPL   = 9;
  localparam int LB    = 144;

  typedef struct {
    logic [7:0]    addr;
    logic [LB-1:0] data;
  } line_t;

  logic          clk_12mhz = 0;
  logic          rst_n, frame_start, line_ready;
  logic          mem_rd_en, line_valid, frame_busy, frame_done;
  logic [10:0]   mem_addr;
  logic [15:0]   mem_rd_data;
  logic [7:0]    line_addr;
  logic [LB-1:0] line_data;

  logic [15:0] mem [0:2047];
  line_t exp_q[$];
  int errors = 0, checks = 0;
  int xfer_cnt = 0, done_cnt = 0;
  int stall_line = 0, stall_left = 0;
  bit rand_ready = 0;

  sharp_line_feeder #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk_12mhz(clk_12mhz), .rst_n(rst_n), .frame_start(frame_start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr),
    .line_data(line_data), .frame_busy(frame_busy), .frame_done(frame_done)
  );

  initial forever #5 clk_12mhz = ~clk_12mhz;

  // Synchronous-read frame buffer: data valid the cycle after mem_rd_en.
  always @(posedge clk_12mhz) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: line L holds words (L-1)*WPL .. (L-1)*WPL+8, word 0 leftmost.
  task automatic push_frame();
    for (int l = 1; l <= LINES; l++) begin
      line_t e;
      e.addr = 8'(l);
      e.data = '0;
      for (int w = 0; w < WPL; w++) begin
        logic [15:0] v;
        v = mem[(l-1)*WPL + w];
`ifdef SHARP_FEEDER_INVERT_EN
        v = ~v;
`endif
        e.data[LB-1-16*w -: 16] = v;
      end
      exp_q.push_back(e);
    end
  endtask

  // line_ready driver: optional random backpressure plus a forced stall on one line.
  initial begin
    line_ready = 0;
    forever begin
      @(posedge clk_12mhz); #2;
      if (stall_left > 0 && line_valid && line_addr == 8'(stall_line)) begin
        line_ready = 0;
        stall_left--;
      end else if (rand_ready) line_ready = ($urandom_range(0, 3) != 0);
      else line_ready = 1;
    end
  end

  // Monitor: pops the scoreboard on every accepted line.
  initial forever begin
    @(negedge clk_12mhz);
    if (rst_n) begin
      if (frame_done) done_cnt++;
      if (line_valid && line_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) chk("unexpected_line", {136'd0, line_addr}, '0);
        else begin
          line_t e;
          e = exp_q.pop_front();
          chk("line_addr", {136'd0, line_addr}, {136'd0, e.addr});
          chk("line_data", line_data, e.data);
        end
      end
    end
  end

  task automatic start_frame();
    int n;
    @(posedge clk_12mhz); #2;
    frame_start = 1;
    push_frame();
    @(posedge clk_12mhz); #2;
    frame_start = 0;
    chk("first_rd_en", {143'd0, mem_rd_en}, 1);
    chk("first_mem_addr", {133'd0, mem_addr}, '0);
    n = 0;
    while (!line_valid && n < 100) begin
      @(posedge clk_12mhz); #2;
      n++;
    end
    chk("fill_latency", LB'(n), LB'(2*WPL));
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk_12mhz);
      n++;
    end
    chk("frame_done_seen", {143'd0, done_cnt != 0}, 1);
    repeat (2) @(negedge clk_12mhz);
  endtask

  task automatic wait_line(input int l, input bit need_rd);
    int n = 0;
    @(negedge clk_12mhz);
    while (!(line_addr == 8'(l) && (need_rd ? mem_rd_en : line_valid)) && n < 20000) begin
      @(negedge clk_12mhz);
      n++;
    end
    chk("wait_line_timeout", {143'd0, n < 20000}, 1);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_rd_en"}, {143'd0, mem_rd_en}, '0);
    chk({nm, "_valid"}, {143'd0, line_valid}, '0);
    chk({nm, "_busy"},  {143'd0, frame_busy}, '0);
    chk({nm, "_done"},  {143'd0, frame_done}, '0);
  endtask

  initial begin
    logic [LB-1:0] snap;
    bit bad;
    rst_n = 0;
    frame_start = 0;
    for (int a = 0; a < 2048; a++) mem[a] = 16'(a);
    repeat (3) @(posedge clk_12mhz);
    #1;
    chk_idle_outputs("reset");
    chk("reset_line_addr", {136'd0, line_addr}, '0);
    chk("reset_line_data", line_data, '0);
    chk("reset_mem_addr", {133'd0, mem_addr}, '0);
    @(negedge clk_12mhz) rst_n = 1;

    // Frame 1: memory word = address, line_ready held high.
    start_frame();
    wait_done();
    chk("f1_transfers", LB'(xfer_cnt), LB'(LINES));
    chk("f1_done_pulses", LB'(done_cnt), 1);
    chk("f1_queue_empty", LB'(exp_q.size()), '0);
    chk_idle_outputs("f1_after");

    // Frame 2: random data, random backpressure, 50-cycle stall on line 5, stray frame_start on line 20.
    for (int a = 0; a < 2048; a++) mem[a] = 16'($urandom);
    xfer_cnt = 0; done_cnt = 0; rand_ready = 1;
    stall_line = 5; stall_left = 50;
    start_frame();
    wait_line(5, 0);
    snap = line_data;
    bad = 0;
    repeat (40) begin
      @(negedge clk_12mhz);
      if (!line_valid || line_addr != 8'd5 || line_data !== snap || mem_rd_en) bad = 1;
    end
    chk("stall_hold", {143'd0, bad}, '0);
    wait_line(20, 0);
    @(posedge clk_12mhz); #2 frame_start = 1;
    @(posedge clk_12mhz); #2 frame_start = 0;
    wait_done();
    repeat (30) @(negedge clk_12mhz);
    chk("f2_transfers", LB'(xfer_cnt), LB'(LINES));
    chk("f2_done_pulses", LB'(done_cnt), 1);
    chk("f2_queue_empty", LB'(exp_q.size()), '0);
    chk("f2_no_restart", {143'd0, frame_busy}, '0);

    // Frame 3: reset asserted during a line-100 fetch.
    for (int a = 0; a < 2048; a++) mem[a] = 16'($urandom);
    start_frame();
    wait_line(100, 1);
    #1 rst_n = 0;
    #1;
    chk_idle_outputs("midreset");
    chk("midreset_line_addr", {136'd0, line_addr}, '0);
    chk("midreset_line_data", line_data, '0);
    chk("midreset_mem_addr", {133'd0, mem_addr}, '0);
    exp_q.delete();
    @(negedge clk_12mhz) rst_n = 1;
    repeat (10) @(negedge clk_12mhz);
    chk_idle_outputs("post_reset_idle");

    // Frame 4: all-zero memory, restarts at line 1.
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
    xfer_cnt = 0; done_cnt = 0;
    start_frame();
    chk("f4_first_line_addr", {136'd0, line_addr}, 1);
`ifdef SHARP_FEEDER_INVERT_EN
    chk("f4_zero_mem_data", line_data, {LB{1'b1}});
`else
    chk("f4_zero_mem_data", line_data, '0);
`endif
    wait_done();
    chk("f4_transfers", LB'(xfer_cnt), LB'(LINES));
    chk("f4_done_pulses", LB'(done_cnt), 1);
    chk("f4_queue_empty", LB'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sharp_line_feeder.md
SHARP_LINE_FEEDER -- requirements
Module: sharp_line_feeder

Interface
REQ-001 Parameter LINES, default 168, number of gate lines per frame.
REQ-002 Parameter WORDS_PER_LINE, default 9, 16-bit frame-buffer words per line (9x16=144 pixels).
REQ-003 Port clk_12mhz  input  1  system clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  reset; one clock, reset asynchronous active-low.
REQ-005 Port frame_start  input  1  single-cycle request to stream one full frame.
REQ-006 Port mem_rd_en  output  1  frame-buffer read strobe.
REQ-007 Port mem_addr  output  11  frame-buffer word address = (line-1)*WORDS_PER_LINE + word.
REQ-008 Port mem_rd_data  input  16  read data, valid exactly 1 cycle after mem_rd_en; bit 15 = leftmost pixel.
REQ-009 Port line_valid  output  1  line_addr/line_data hold a complete line.
REQ-010 Port line_ready  input  1  downstream SPI driver accepts the line.
REQ-011 Port line_addr  output  8  gate-line address, 1..LINES.
REQ-012 Port line_data  output  144  pixel data; bit 143 = pixel 0.
REQ-013 Port frame_busy  output  1  high from accepted frame_start until frame_done.
REQ-014 Port frame_done  output  1  single-cycle pulse after last line is accepted.

Function
REQ-015 FSM states IDLE, FETCH, WAIT_RD, PRESENT, DONE.
REQ-016 IDLE: frame_start=1 -> line counter=1, word counter=0, go FETCH; frame_busy set the same edge.
REQ-017 FETCH: assert mem_rd_en with mem_addr for current word for one cycle, go WAIT_RD.
REQ-018 WAIT_RD: capture mem_rd_data into word slot [143-16*w -: 16]; if w==WORDS_PER_LINE-1 go PRESENT, else w++ and go FETCH.
REQ-019 Per-line fill latency is exactly 2*WORDS_PER_LINE cycles (18 by default).
REQ-020 PRESENT: line_valid=1; line_addr and line_data stable until transfer (line_valid&&line_ready).
REQ-021 On transfer at line<LINES: line++, w=0, line_valid drops next cycle, go FETCH.
REQ-022 On transfer at line==LINES: go DONE; DONE pulses frame_done one cycle, clears frame_busy, returns IDLE.
REQ-023 frame_start while frame_busy=1 is ignored; no restart, no queuing.
REQ-024 line_ready while line_valid=0 has no effect.
REQ-025 line_addr is 1-based (Sharp gate-line numbering); 0 never driven while line_valid=1.
REQ-026 mem_addr computed without overflow for LINES*WORDS_PER_LINE <= 2048.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE; line_valid, mem_rd_en, frame_busy, frame_done=0; line_addr=0; line_data=0; mem_addr=0.
REQ-028 Reset mid-frame abandons the frame; after release the block waits for a new frame_start.

Configuration
REQ-029 Macro SHARP_FEEDER_INVERT_EN defined: each captured word bitwise inverted before storage (frame buffer 1=black, panel 1=white).
REQ-030 Macro undefined: words stored unmodified; no inversion logic present.

Structure
REQ-031 Package sharp_pkg holds LINE_BITS=144, WORD_W=16, default LINES=168, and the FSM state enum typedef.
REQ-032 One sub-module sharp_word_packer: shifts/inserts 16-bit words into the 144-bit line register, with the optional inversion.

Verification
REQ-033 Reset then frame_start, memory word = address, line_ready tied 1 -> 168 lines, line 1 data words 0..8, frame_done after line 168.
REQ-034 line_ready held 0 for 50 cycles on line 5 -> line_valid stays 1, line_addr=5, data unchanged, no mem_rd_en.
REQ-035 frame_start pulsed during line 20 -> ignored; exactly 168 transfers, one frame_done.
REQ-036 rst_n low during line 100 fetch -> all outputs reset immediately; next frame_start restarts at line_addr=1.
REQ-037 SHARP_FEEDER_INVERT_EN defined, memory all 16'h0000 -> line_data all ones; undefined -> all zeros.
REQ-038 Line 1 timing: first mem_rd_en the cycle after frame_start, line_valid exactly 18 cycles after the first mem_rd_en.
